// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and
// the clocks-per-bit derivation both directions must agree on.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned uart_half(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return uart_div(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so an
// idle-high line does not look like activity coming out of reset.
module uart_rx_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampling bit FSM feeding a single-entry
// valid/ready output register that never back-pressures the line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV     = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF    = uart_half(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  logic        rx_s;
  logic        rx_h_q;
  logic        fall;
  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        stop_smp;
  logic        deliver;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (uart_rxd),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) rx_h_q <= 1'b1;
    else        rx_h_q <= rx_s;
  end

  assign fall     = rx_h_q & ~rx_s;
  assign stop_smp = (state_q == ST_STOP) && (cnt_q == DIV_M1);
  assign deliver  = stop_smp & rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Only a 1->0 transition arms; a held-low break cannot restart.
          if (fall) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == DIV_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == DIV_M1) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // LSB arrives first, so shifting right leaves bit 0 in place after eight bits.
  always_ff @(posedge clk) begin
    if ((state_q == ST_DATA) && (cnt_q == DIV_M1)) shift_q <= {rx_s, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_smp & ~rx_s;
      overrun_q   <= deliver & rx_valid_q & ~rx_ready;
      if (deliver && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver serialises frames and queues the
// expected outcome; a monitor pops and compares whenever the DUT reports one.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 115200;
  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  // Pin edge to output change: 2 sync clocks, start sample, 9 bit times, 1 register.
  localparam int LAT  = 3 + HALF + 9 * DIV;

  // Outcome codes for a frame with a good stop bit.
  localparam int M_BYTE_T = 0;  // delivered, handshake expected at LAT
  localparam int M_BYTE_U = 1;  // delivered, handshake later (consumer stalled)
  localparam int M_OVR    = 2;  // dropped with overrun at LAT
  localparam int M_NONE   = 3;  // nothing reported (discarded by reset)

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int frame_start = 0;
  int frame_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_data[$];
  int   exp_ferr[$];
  int   exp_ovr[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int d;
    if (reset) begin
      if (frame_err) begin
        if (exp_ferr.size() == 0) check("unexpected_frame_err", 1, 0);
        else begin
          d = exp_ferr.pop_front();
          check("frame_err_time", cyc, d);
        end
      end
      if (overrun) begin
        if (exp_ovr.size() == 0) check("unexpected_overrun", 1, 0);
        else begin
          d = exp_ovr.pop_front();
          check("overrun_time", cyc, d);
        end
      end
      if (rx_valid && rx_ready) begin
        if (exp_data.size() == 0) check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_data.pop_front();
          check("rx_data", rx_data, e.data);
          if (e.due >= 0) check("rx_data_time", cyc, e.due);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input int brk, input int mode);
    logic [9:0] bits;
    exp_t e;
    bits = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    frame_start = cyc;
    frame_cnt++;
    if (!stop) exp_ferr.push_back(frame_start + LAT);
    else if (mode == M_BYTE_T) begin
      e.data = b; e.due = frame_start + LAT; exp_data.push_back(e);
    end else if (mode == M_BYTE_U) begin
      e.data = b; e.due = -1; exp_data.push_back(e);
    end else if (mode == M_OVR) exp_ovr.push_back(frame_start + LAT);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (per) @(posedge clk);
      #1;
    end
    if (!stop) begin
      repeat (brk) @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
  endtask

  initial begin
    #(64'd10 * 64'd200000);
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    int per;
    logic [7:0] b;
    logic stp;

    reset = 1'b0;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(10);

    // Clean frame with consumer ready.
    send_frame(8'h55, 1'b1, DIV, 0, M_BYTE_T);
    idle(20);

    // Short low glitch: false start, FSM back in IDLE right after the start sample.
    @(posedge clk);
    #1 uart_rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (HALF + 4 - 100) @(posedge clk);
    @(negedge clk);
    check("glitch_state_idle", dut.state_q, ST_IDLE);
    idle(20);

    // Bad stop bit followed by a held break, then a good frame.
    send_frame(8'hA5, 1'b0, DIV, 2 * DIV, M_NONE);
    idle(20);
    @(negedge clk);
    check("ferr_no_valid", rx_valid, 0);
    send_frame(8'h3C, 1'b1, DIV, 0, M_BYTE_T);
    idle(20);

    // Stalled consumer: second byte overruns, first is held.
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, DIV, 0, M_BYTE_U);
    idle(20);
    @(negedge clk);
    check("held_valid", rx_valid, 1);
    check("held_data", rx_data, 8'h12);
    send_frame(8'h34, 1'b1, DIV, 0, M_OVR);
    idle(20);
    @(negedge clk);
    check("overrun_keeps_data", rx_data, 8'h12);
    check("overrun_keeps_valid", rx_valid, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop_after_accept", rx_valid, 0);
    idle(20);

    // Accept in exactly the completion cycle of the next byte.
    rx_ready = 1'b0;
    send_frame(8'h9A, 1'b1, DIV, 0, M_BYTE_U);
    idle(20);
    fc0 = frame_cnt;
    fork
      send_frame(8'h6B, 1'b1, DIV, 0, M_BYTE_T);
      begin
        wait (frame_cnt != fc0);
        repeat (2 + HALF + 9 * DIV) @(posedge clk);
        #1 rx_ready = 1'b1;
      end
    join
    idle(20);

    // Reset during data bit 4 discards both the held byte and the partial frame.
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, DIV, 0, M_NONE);
    idle(20);
    @(negedge clk);
    check("pre_reset_held", rx_valid, 1);
    fc0 = frame_cnt;
    fork
      send_frame(8'hF5, 1'b1, DIV, 0, M_NONE);
      begin
        wait (frame_cnt != fc0);
        repeat (5 * DIV + DIV / 2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
      end
    join
    rx_ready = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1, DIV, 0, M_BYTE_T);
    idle(20);

    // Random bytes, occasional bad stop bit, bit period within +/-2 %.
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       per = DIV;
        1:       per = (DIV * 98) / 100;
        default: per = (DIV * 102) / 100;
      endcase
      send_frame(b, stp, per, 0, M_BYTE_T);
      idle($urandom_range(1, 40));
    end

    idle(50);
    check("pending_bytes", exp_data.size(), 0);
    check("pending_frame_err", exp_ferr.size(), 0);
    check("pending_overrun", exp_ovr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
